// File: rtl/span_fill_pkg.sv
// Shared widths, clear values and FSM state encoding for the span_fill scanline writer.
// Every other file in this block imports this package.
package span_fill_pkg;

    localparam int LINE_WIDTH = 256;
    localparam int RAM_A_BITS = 8;
    localparam int RAM_D_BITS = 8;
    localparam int X_BITS     = 10;

    localparam logic [23:0]           BG_RGB    = 24'h000000;
    localparam logic [RAM_D_BITS-1:0] DEPTH_FAR = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RD    = 2'd2,
        ST_WR    = 2'd3
    } state_t;

    // One line-buffer word across the four SRAMs, r in the MSBs.
    typedef struct packed {
        logic [RAM_D_BITS-1:0] r;
        logic [RAM_D_BITS-1:0] g;
        logic [RAM_D_BITS-1:0] b;
        logic [RAM_D_BITS-1:0] d;
    } pixel_t;

endpackage

// File: rtl/span_fill_if.sv
// Request handshake plus render-side line-buffer bus of span_fill.
// slave = span_fill itself, master = the span producer / line-buffer owner.
interface span_fill_if;
    import span_fill_pkg::*;

    logic                  clear_valid;
    logic                  clear_ready;
    logic                  span_valid;
    logic                  span_ready;
    logic [X_BITS-1:0]     span_x_start;
    logic [X_BITS-1:0]     span_x_end;
    logic [23:0]           span_rgb;
    logic [RAM_D_BITS-1:0] span_depth;
    logic                  busy;
    logic [RAM_A_BITS-1:0] buf_a;
    logic                  buf_cen;
    logic                  buf_gwen;
    logic [RAM_D_BITS-1:0] buf_wen;
    logic [RAM_D_BITS-1:0] buf_r_d;
    logic [RAM_D_BITS-1:0] buf_g_d;
    logic [RAM_D_BITS-1:0] buf_b_d;
    logic [RAM_D_BITS-1:0] buf_d_d;
    logic [RAM_D_BITS-1:0] buf_d_q;

    modport slave (
        input  clear_valid, span_valid, span_x_start, span_x_end, span_rgb, span_depth, buf_d_q,
        output clear_ready, span_ready, busy, buf_a, buf_cen, buf_gwen, buf_wen,
               buf_r_d, buf_g_d, buf_b_d, buf_d_d
    );

    modport master (
        output clear_valid, span_valid, span_x_start, span_x_end, span_rgb, span_depth, buf_d_q,
        input  clear_ready, span_ready, busy, buf_a, buf_cen, buf_gwen, buf_wen,
               buf_r_d, buf_g_d, buf_b_d, buf_d_d
    );

endinterface

// File: rtl/span_fill_clip.sv
// Combinational span clipper: clamps x_end to the last pixel of the line and flags
// spans that touch no pixel at all.
module span_clip
    import span_fill_pkg::*;
#(
    parameter int P_LINE_WIDTH = LINE_WIDTH
) (
    input  logic [X_BITS-1:0] i_x_start,
    input  logic [X_BITS-1:0] i_x_end,
    output logic [X_BITS-1:0] o_x_end_clip,
    output logic              o_empty
);

    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(P_LINE_WIDTH - 1);

    assign o_x_end_clip = (i_x_end > X_LAST) ? X_LAST : i_x_end;
    assign o_empty      = (i_x_start > X_LAST) || (i_x_start > o_x_end_clip);

endmodule

// File: rtl/span_fill.sv
// Render-side scanline writer: clears the line buffer, then fills depth-tested spans
// with a read-compare-write pair per pixel.
module span_fill
    import span_fill_pkg::*;
#(
    parameter int                    P_LINE_WIDTH = LINE_WIDTH,
    parameter logic [23:0]           P_BG_RGB     = BG_RGB,
    parameter logic [RAM_D_BITS-1:0] P_DEPTH_FAR  = DEPTH_FAR
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    span_fill_if.slave bus
);

    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(P_LINE_WIDTH - 1);

    state_t                r_state_reg, r_state_next;
    logic [X_BITS-1:0]     r_x_reg, r_x_next;
    logic [X_BITS-1:0]     r_end_reg, r_end_next;
    logic                  r_ready_reg, r_ready_next;
    logic                  r_busy_reg, r_busy_next;
    logic [RAM_A_BITS-1:0] r_a_reg, r_a_next;
    logic                  r_cen_reg, r_cen_next;
    logic                  r_gwen_reg, r_gwen_next;
    logic                  r_wr_reg, r_wr_next;
    logic [RAM_D_BITS-1:0] r_wen_reg, r_wen_next;
    pixel_t                r_pix_reg, r_pix_next;

    logic [X_BITS-1:0] w_end_clip;
    logic              w_empty;
    logic              w_clear_fire;
    logic              w_span_fire;
    logic [X_BITS-1:0] w_x_inc;

    span_clip #(
        .P_LINE_WIDTH (P_LINE_WIDTH)
    ) u_clip (
        .i_x_start    (bus.span_x_start),
        .i_x_end      (bus.span_x_end),
        .o_x_end_clip (w_end_clip),
        .o_empty      (w_empty)
    );

    // Clear has priority: a simultaneous span simply sees no ready and waits.
    assign w_clear_fire = r_ready_reg & bus.clear_valid;
    assign w_span_fire  = r_ready_reg & bus.span_valid & ~bus.clear_valid;
    assign w_x_inc      = X_BITS'(r_x_reg + 1'b1);

    always_comb begin
        r_state_next = r_state_reg;
        r_x_next     = r_x_reg;
        r_end_next   = r_end_reg;
        r_a_next     = r_a_reg;
        r_cen_next   = 1'b1;
        r_gwen_next  = 1'b1;
        r_wen_next   = '1;
        r_wr_next    = 1'b0;
        r_pix_next   = r_pix_reg;

        case (r_state_reg)
            ST_IDLE: begin
                if (w_clear_fire) begin
                    r_state_next = ST_CLEAR;
                    r_x_next     = '0;
                    r_a_next     = '0;
                    r_cen_next   = 1'b0;
                    r_gwen_next  = 1'b0;
                    r_wen_next   = '0;
                    r_pix_next   = pixel_t'({P_BG_RGB, P_DEPTH_FAR});
                end else if (w_span_fire && !w_empty) begin
                    r_state_next = ST_RD;
                    r_x_next     = bus.span_x_start;
                    r_end_next   = w_end_clip;
                    r_a_next     = bus.span_x_start[RAM_A_BITS-1:0];
                    r_cen_next   = 1'b0;
                    r_pix_next   = pixel_t'({bus.span_rgb, bus.span_depth});
                end
            end
            ST_CLEAR: begin
                if (r_x_reg == X_LAST) begin
                    r_state_next = ST_IDLE;
                end else begin
                    r_x_next    = w_x_inc;
                    r_a_next    = w_x_inc[RAM_A_BITS-1:0];
                    r_cen_next  = 1'b0;
                    r_gwen_next = 1'b0;
                    r_wen_next  = '0;
                end
            end
            ST_RD: begin
                r_state_next = ST_WR;
                r_cen_next   = 1'b0;
                r_wen_next   = '0;
                r_wr_next    = 1'b1;
            end
            ST_WR: begin
                if (r_x_reg == r_end_reg) begin
                    r_state_next = ST_IDLE;
                end else begin
                    r_state_next = ST_RD;
                    r_x_next     = w_x_inc;
                    r_a_next     = w_x_inc[RAM_A_BITS-1:0];
                    r_cen_next   = 1'b0;
                end
            end
            default: r_state_next = ST_IDLE;
        endcase

        r_ready_next = (r_state_next == ST_IDLE);
        r_busy_next  = (r_state_next != ST_IDLE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state_reg <= ST_IDLE;
            r_x_reg     <= '0;
            r_end_reg   <= '0;
            r_ready_reg <= 1'b0;
            r_busy_reg  <= 1'b0;
            r_a_reg     <= '0;
            r_cen_reg   <= 1'b1;
            r_gwen_reg  <= 1'b1;
            r_wr_reg    <= 1'b0;
            r_wen_reg   <= '1;
            r_pix_reg   <= '0;
        end else begin
            r_state_reg <= r_state_next;
            r_x_reg     <= r_x_next;
            r_end_reg   <= r_end_next;
            r_ready_reg <= r_ready_next;
            r_busy_reg  <= r_busy_next;
            r_a_reg     <= r_a_next;
            r_cen_reg   <= r_cen_next;
            r_gwen_reg  <= r_gwen_next;
            r_wr_reg    <= r_wr_next;
            r_wen_reg   <= r_wen_next;
            r_pix_reg   <= r_pix_next;
        end
    end

    assign bus.clear_ready = r_ready_reg;
    assign bus.span_ready  = r_ready_reg & ~bus.clear_valid;
    assign bus.busy        = r_busy_reg;
    assign bus.buf_a       = r_a_reg;
    assign bus.buf_cen     = r_cen_reg;
    assign bus.buf_wen     = r_wen_reg;
    assign bus.buf_r_d     = r_pix_reg.r;
    assign bus.buf_g_d     = r_pix_reg.g;
    assign bus.buf_b_d     = r_pix_reg.b;
    assign bus.buf_d_d     = r_pix_reg.d;

    // The old depth only arrives during the WR cycle itself, so the write strobe is
    // the one place where the SRAM read data gates a registered output.
    assign bus.buf_gwen = r_gwen_reg & ~(r_wr_reg & (r_pix_reg.d < bus.buf_d_q));

endmodule

// File: tb/tb_span_fill.sv
// Randomized scoreboard bench for span_fill: a line-buffer reference model predicts
// every SRAM write, a monitor pops and compares each write the DUT actually makes.
module tb_span_fill;
    import span_fill_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    span_fill_if bus ();

    span_fill dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    int acc_cnt = 0;

    // Expected write: {addr, wen, r, g, b, d}
    logic [47:0] exp_q[$];
    logic [47:0] mon_e;

    logic [7:0] ref_r[256], ref_g[256], ref_b[256], ref_d[256];
    logic [7:0] mem_r[256], mem_g[256], mem_b[256], mem_d[256];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Line buffer SRAM model, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.buf_cen == 1'b0) begin
            if (bus.buf_gwen == 1'b0) begin
                mem_r[bus.buf_a] <= (mem_r[bus.buf_a] & bus.buf_wen) | (bus.buf_r_d & ~bus.buf_wen);
                mem_g[bus.buf_a] <= (mem_g[bus.buf_a] & bus.buf_wen) | (bus.buf_g_d & ~bus.buf_wen);
                mem_b[bus.buf_a] <= (mem_b[bus.buf_a] & bus.buf_wen) | (bus.buf_b_d & ~bus.buf_wen);
                mem_d[bus.buf_a] <= (mem_d[bus.buf_a] & bus.buf_wen) | (bus.buf_d_d & ~bus.buf_wen);
            end
            bus.buf_d_q <= mem_d[bus.buf_a];
        end
    end

    // Monitor: every SRAM write must match the next predicted write.
    always @(negedge clk) begin
        if (bus.buf_cen === 1'b0) begin
            acc_cnt++;
            if (bus.buf_gwen === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL write_unexpected: got write a=%0d d=%h, expected no write",
                             bus.buf_a, bus.buf_d_d);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("write", 64'({bus.buf_a, bus.buf_wen, bus.buf_r_d, bus.buf_g_d,
                                      bus.buf_b_d, bus.buf_d_d}), 64'(mon_e));
                end
            end
        end
    end

    task automatic model_clear();
        for (int x = 0; x < 256; x++) begin
            ref_r[x] = BG_RGB[23:16];
            ref_g[x] = BG_RGB[15:8];
            ref_b[x] = BG_RGB[7:0];
            ref_d[x] = DEPTH_FAR;
            exp_q.push_back({8'(x), 8'h00, BG_RGB, DEPTH_FAR});
        end
    endtask

    // Returns the number of pixels the span covers after clipping.
    task automatic model_span(input int xs, input int xe, input logic [23:0] rgb,
                              input logic [7:0] dep, output int n_pix);
        int last;
        last  = (xe > 255) ? 255 : xe;
        n_pix = (xs > last) ? 0 : last - xs + 1;
        for (int x = xs; x <= last; x++) begin
            if (dep < ref_d[x]) begin
                {ref_r[x], ref_g[x], ref_b[x]} = rgb;
                ref_d[x] = dep;
                exp_q.push_back({8'(x), 8'h00, rgb, dep});
            end
        end
    endtask

    task automatic drive_span(input int xs, input int xe, input logic [23:0] rgb, input logic [7:0] dep);
        bus.span_x_start = 10'(xs);
        bus.span_x_end   = 10'(xe);
        bus.span_rgb     = rgb;
        bus.span_depth   = dep;
    endtask

    // From just after the accept edge, count busy cycles until ready returns.
    task automatic wait_idle(output int bc);
        int guard;
        bc = 0;
        guard = 0;
        forever begin
            @(negedge clk);
            guard++;
            if (bus.busy) bc++;
            else if (bus.clear_ready) break;
            if (guard > 2000) begin
                n_cmp++;
                n_err++;
                $display("FAIL idle_timeout: got busy after %0d cycles, expected ready", guard);
                break;
            end
        end
    endtask

    task automatic issue(input bit is_clear, input int xs, input int xe, input logic [23:0] rgb,
                         input logic [7:0] dep, output int bc);
        int guard;
        @(negedge clk);
        if (is_clear) bus.clear_valid = 1'b1;
        else begin
            drive_span(xs, xe, rgb, dep);
            bus.span_valid = 1'b1;
        end
        #1;
        guard = 0;
        while (!(is_clear ? bus.clear_ready : bus.span_ready) && guard < 2000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 2000) begin
            n_cmp++;
            n_err++;
            $display("FAIL handshake_timeout: got no ready, expected ready");
        end
        @(posedge clk);
        #1;
        bus.clear_valid = 1'b0;
        bus.span_valid  = 1'b0;
        wait_idle(bc);
    endtask

    task automatic run_op(input bit is_clear, input int xs, input int xe, input logic [23:0] rgb,
                          input logic [7:0] dep, input string tag);
        int n_pix, bc, acc0, exp_busy;
        if (is_clear) begin
            model_clear();
            exp_busy = 256;
        end else begin
            model_span(xs, xe, rgb, dep, n_pix);
            exp_busy = 2 * n_pix;
        end
        acc0 = acc_cnt;
        issue(is_clear, xs, xe, rgb, dep, bc);
        chk({tag, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
        chk({tag, "_access_cycles"}, 64'(acc_cnt - acc0), 64'(exp_busy));
        chk({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
        $display("op %s: x %0d..%0d rgb=%h d=%h busy=%0d", tag, xs, xe, rgb, dep, bc);
    endtask

    initial begin
        int bc, n_pix, waited, guard, r, xs, xe;
        logic [23:0] rgb;
        logic [7:0]  dep;

        #5_000_000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, n_pix, waited, guard, r, xs, xe;
        logic [23:0] rgb;
        logic [7:0]  dep;

        bus.clear_valid = 1'b0;
        bus.span_valid  = 1'b0;
        drive_span(0, 0, 24'h0, 8'h0);
        for (int x = 0; x < 256; x++) begin
            ref_r[x] = 8'h0; ref_g[x] = 8'h0; ref_b[x] = 8'h0; ref_d[x] = 8'h0;
        end

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cen", 64'(bus.buf_cen), 64'd1);
        chk("rst_gwen", 64'(bus.buf_gwen), 64'd1);
        chk("rst_wen", 64'(bus.buf_wen), 64'hFF);
        chk("rst_addr", 64'(bus.buf_a), 64'd0);
        chk("rst_data", 64'({bus.buf_r_d, bus.buf_g_d, bus.buf_b_d, bus.buf_d_d}), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ready", 64'({bus.clear_ready, bus.span_ready}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(bus.clear_ready), 64'd1);

        // Directed sequence
        run_op(1'b1, 0, 0, 24'h0, 8'h0, "clear");
        run_op(1'b0, 10, 12, 24'h123456, 8'h40, "span10_12");
        run_op(1'b0, 11, 11, 24'hABCDEF, 8'h40, "depth_equal");
        run_op(1'b0, 11, 11, 24'hABCDEF, 8'h3F, "depth_nearer");
        run_op(1'b0, 250, 300, 24'h0F0F0F, 8'h20, "clip_end");
        run_op(1'b0, 20, 10, 24'h111111, 8'h01, "empty_reversed");
        run_op(1'b0, 256, 260, 24'h222222, 8'h01, "empty_offline");

        // Clear and span requested together: clear wins, span follows
        model_clear();
        model_span(5, 7, 24'h5A5A5A, 8'h10, n_pix);
        @(negedge clk);
        drive_span(5, 7, 24'h5A5A5A, 8'h10);
        bus.clear_valid = 1'b1;
        bus.span_valid  = 1'b1;
        #1;
        chk("both_clear_ready", 64'(bus.clear_ready), 64'd1);
        chk("both_span_ready", 64'(bus.span_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.clear_valid = 1'b0;
        waited = 0;
        while (!bus.span_ready && waited < 2000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("span_wait_cycles", 64'(waited), 64'd257);
        @(posedge clk);
        #1;
        bus.span_valid = 1'b0;
        wait_idle(bc);
        chk("after_clear_span_busy", 64'(bc), 64'(2 * n_pix));
        chk("after_clear_pending", 64'(exp_q.size()), 64'd0);
        $display("op both_valid: clear then x 5..7 busy=%0d", bc);

        // Randomized spans against the line model
        for (int i = 0; i < 40; i++) begin
            r   = $urandom_range(0, 9);
            xs  = $urandom_range(0, 280);
            xe  = (r < 3) ? $urandom_range(0, 300) : xs + $urandom_range(0, 40);
            rgb = 24'($urandom);
            dep = 8'($urandom_range(0, 255));
            if (r == 0) run_op(1'b1, 0, 0, 24'h0, 8'h0, "rand_clear");
            else        run_op(1'b0, xs, xe, rgb, dep, "rand_span");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Reset in the middle of a span: pixels 0..4 land, 5..9 never do
        run_op(1'b1, 0, 0, 24'h0, 8'h0, "clear_pre_reset");
        model_span(0, 4, 24'hC0FFEE, 8'h10, n_pix);
        @(negedge clk);
        drive_span(0, 9, 24'hC0FFEE, 8'h10);
        bus.span_valid = 1'b1;
        #1;
        guard = 0;
        while (!bus.span_ready && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        @(posedge clk);
        #1;
        bus.span_valid = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(bus.buf_a == 8'd5 && bus.buf_cen == 1'b0) && guard < 100);
        chk("reach_x5", 64'(bus.buf_a), 64'd5);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cen", 64'(bus.buf_cen), 64'd1);
        chk("midrst_gwen", 64'(bus.buf_gwen), 64'd1);
        chk("midrst_wen", 64'(bus.buf_wen), 64'hFF);
        chk("midrst_addr", 64'(bus.buf_a), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 64'(bus.clear_ready), 64'd1);
        chk("midrst_pending", 64'(exp_q.size()), 64'd0);
        repeat (4) @(negedge clk);
        $display("op reset_mid_span: x 0..9 abandoned at x=5");

        // Final line buffer contents against the model
        for (int x = 0; x < 256; x++) begin
            chk($sformatf("mem_%0d", x), 64'({mem_r[x], mem_g[x], mem_b[x], mem_d[x]}),
                64'({ref_r[x], ref_g[x], ref_b[x], ref_d[x]}));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
